// File: rtl/neuro_pkg.sv
// Shared definitions for the sensor front-end blocks: mode encoding and a
// width helper for sizing index and counter registers.
package neuro_pkg;

  // Channel selection mode of chan_scan_mux.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Number of bits needed to index n distinct values, never less than 1.
  // For n >= 2 this equals $clog2(n); for n == 1 it still yields a usable
  // 1-bit register instead of a zero-width one.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : neuro_pkg

// File: rtl/chan_scan_mux_rr_next_ch.sv
// Round-robin successor search: returns the index of the next set bit of
// mask_i strictly after ptr_i, wrapping modulo N_CH. When ptr_i is the only
// set bit it is returned unchanged; an all-zero mask also returns ptr_i.
// Purely combinational.
module rr_next_ch
  import neuro_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = clog2_w(N_CH)
) (
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_CH-1:0]  mask_i,
  output logic [SEL_W-1:0] next_o
);

  // One extra bit so ptr_i + distance (at most 2*N_CH-1) never overflows
  // before the wrap subtraction.
  logic [SEL_W:0] idx;

  // Walk distances from farthest to nearest; the nearest set bit after ptr_i
  // is therefore the last one written and wins.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_o = ptr_i;
    idx    = '0;
    for (int d = N_CH; d >= 1; d--) begin
      idx = {1'b0, ptr_i} + (SEL_W + 1)'(d);
      if (idx >= (SEL_W + 1)'(N_CH)) begin
        idx = idx - (SEL_W + 1)'(N_CH);
      end
      if (mask_i[idx[SEL_W-1:0]]) begin
        next_o = idx[SEL_W-1:0];
      end
    end
  end

endmodule : rr_next_ch

// File: rtl/chan_scan_mux.sv
// Registered channel multiplexer for the sensor front end. Picks one W-bit
// channel out of N_CH either from a direct select (manual mode) or by a
// round-robin scan over ch_mask with DWELL cycles per channel, and presents
// the sample plus its channel index on a valid/ready output slot.
module chan_scan_mux
  import neuro_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SEL_W = clog2_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] x,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              sel_err
);

  localparam int                DCNT_W    = clog2_w(DWELL);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  // Sequencing state.
  logic [SEL_W-1:0]  ptr_q,  ptr_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  // Output slot.
  logic [W-1:0]      y_q,       y_d;
  logic [SEL_W-1:0]  y_ch_q,    y_ch_d;
  logic              y_valid_q, y_valid_d;
  logic              sel_err_q, sel_err_d;

  // Decoded controls.
  mode_e             mode_s;
  logic              slot_free;
  logic              sel_ok;
  logic              mask_any;
  logic              ptr_enabled;
  logic [SEL_W-1:0]  next_ch;
  logic [SEL_W-1:0]  cap_ch;
  logic [W-1:0]      cap_data;
  logic              cap;

  assign mode_s      = mode_e'(mode);
  // The slot accepts a new sample when empty or when it is popped this cycle.
  assign slot_free   = !y_valid_q || y_ready;
  // For a power-of-two N_CH every select is legal; otherwise the top codes are not.
  assign sel_ok      = (32'(sel) < 32'(N_CH));
  assign mask_any    = |ch_mask;
  assign ptr_enabled = ch_mask[ptr_q];

  rr_next_ch #(
    .N_CH (N_CH)
  ) u_rr_next_ch (
    .ptr_i  (ptr_q),
    .mask_i (ch_mask),
    .next_o (next_ch)
  );

  // Channel that would be captured this cycle, chosen by mode alone so the
  // data mux does not depend on the capture decision.
  always_comb begin
    cap_ch = (mode_s == MODE_MANUAL) ? sel : ptr_q;
  end

  // Data mux: pick channel cap_ch out of the packed input bus.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cap_ch == SEL_W'(k)) begin
        cap_data = x[k*W +: W];
      end
    end
  end

  // Sequencing and capture decision: dwell counting, pointer advance, output
  // slot refill and the sticky select-error flag.
  always_comb begin
    ptr_d     = ptr_q;
    dcnt_d    = dcnt_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    sel_err_d = sel_err_q;
    cap       = 1'b0;

    // A pending sample leaves when the consumer takes it, even while
    // sequencing is frozen by en=0.
    if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end

    if (mode_s == MODE_MANUAL) begin
      // Manual mode keeps the dwell counter cleared so a later switch to
      // scan starts a fresh dwell at the current pointer.
      dcnt_d = '0;
      if (en) begin
        if (!sel_ok) begin
          sel_err_d = 1'b1;
        end else if (slot_free) begin
          cap = 1'b1;
        end
      end
    end else if (en && mask_any) begin
      if (!ptr_enabled) begin
        // Pointer sits on a masked-out channel: spend one cycle skipping.
        ptr_d  = next_ch;
        dcnt_d = '0;
      end else if (dcnt_q != DCNT_LAST) begin
        dcnt_d = dcnt_q + 1'b1;
      end else if (slot_free) begin
        cap    = 1'b1;
        ptr_d  = next_ch;
        dcnt_d = '0;
      end
      // Otherwise the dwell is complete but the slot is full: hold at
      // DCNT_LAST with the pointer parked until the consumer pops.
    end

    if (cap) begin
      y_d       = cap_data;
      y_ch_d    = cap_ch;
      y_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset; an in-flight sample
  // is dropped by clearing y_valid.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      dcnt_q    <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      dcnt_q    <= dcnt_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;

endmodule : chan_scan_mux

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: an 8-channel instance for manual,
// scan, backpressure, empty-mask and reset sequences, plus a 6-channel
// instance for the out-of-range select error.
module tb_chan_scan_mux;

  // ---------------- clock and DUT signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic [63:0] x;
  logic [2:0]  sel;
  logic        mode;
  logic        en;
  logic [7:0]  ch_mask;
  logic [7:0]  y;
  logic [2:0]  y_ch;
  logic        y_valid;
  logic        y_ready;
  logic        sel_err;

  logic [47:0] x6;
  logic [2:0]  sel6;
  logic        mode6;
  logic        en6;
  logic [5:0]  ch_mask6;
  logic [7:0]  y6;
  logic [2:0]  y_ch6;
  logic        y_valid6;
  logic        y_ready6;
  logic        sel_err6;

  chan_scan_mux #(.N_CH(8), .W(8), .DWELL(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .sel     (sel),
    .mode    (mode),
    .en      (en),
    .ch_mask (ch_mask),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel_err (sel_err)
  );

  chan_scan_mux #(.N_CH(6), .W(8), .DWELL(4)) u_dut6 (
    .clk     (clk),
    .rst     (rst),
    .x       (x6),
    .sel     (sel6),
    .mode    (mode6),
    .en      (en6),
    .ch_mask (ch_mask6),
    .y       (y6),
    .y_ch    (y_ch6),
    .y_valid (y_valid6),
    .y_ready (y_ready6),
    .sel_err (sel_err6)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] ch;
  } sb_item_t;

  sb_item_t sb_q[$];

  logic mon_on  = 1'b0;
  logic gap_chk = 1'b0;
  int   last_pop = -1;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp_y;
    logic [2:0] exp_ch;
  } man_vec_t;

  man_vec_t man_tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Channel k of the 8-channel bus carries 8'h10+k.
  task automatic push_exp(input int ch);
    sb_item_t it;
    it.y  = 8'(16 + ch);
    it.ch = 3'(ch);
    sb_q.push_back(it);
  endtask

  task automatic reset_all();
    en  = 1'b0;
    en6 = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb_q.delete();
    last_pop = -1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      tick(1);
    end
    check(name, sb_q.size(), 0);
  endtask

  // Count edges until y_valid is seen (0 if the budget expires).
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (y_valid) begin
        n = i;
        break;
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every accepted transfer pops one expected sample.
  always @(negedge clk) begin
    if (mon_on && y_valid && y_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got y=0x%0h ch=%0d, expected no sample (cycle %0d)", y, y_ch, cyc);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        check("sb_y", 32'(y), 32'(e.y));
        check("sb_ch", 32'(y_ch), 32'(e.ch));
        if (gap_chk && last_pop >= 0) begin
          check("scan_gap", cyc - last_pop, 4);
        end
        last_pop = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    for (int k = 0; k < 8; k++) x[k*8 +: 8] = 8'(16 + k);
    for (int k = 0; k < 6; k++) x6[k*8 +: 8] = 8'(160 + k);
    for (int i = 0; i < 8; i++) begin
      man_tbl[i].sel    = 3'(i);
      man_tbl[i].exp_y  = 8'(16 + i);
      man_tbl[i].exp_ch = 3'(i);
    end

    rst = 1'b1;
    sel = '0; mode = 1'b0; en = 1'b0; ch_mask = '0; y_ready = 1'b1;
    sel6 = '0; mode6 = 1'b0; en6 = 1'b0; ch_mask6 = '0; y_ready6 = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_y", 32'(y), 0);
    check("rst_y_ch", 32'(y_ch), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    check("rst_ptr", 32'(u_dut.ptr_q), 0);
    check("rst_dcnt", 32'(u_dut.dcnt_q), 0);
    check("rst6_sel_err", 32'(sel_err6), 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // ---- 6-channel instance: out-of-range select, sticky error ----
    mode6 = 1'b0; en6 = 1'b1; sel6 = 3'd5;
    tick(1); @(negedge clk);
    check("n6_sel5_y", 32'(y6), 32'h A5);
    check("n6_sel5_valid", 32'(y_valid6), 1);
    check("n6_sel5_err", 32'(sel_err6), 0);
    tick(1);
    sel6 = 3'd7;
    tick(1); @(negedge clk);
    check("n6_sel7_err", 32'(sel_err6), 1);
    check("n6_sel7_nocap", 32'(y_valid6), 0);
    tick(1);
    sel6 = 3'd6;
    tick(1); @(negedge clk);
    check("n6_sel6_nocap", 32'(y_valid6), 0);
    tick(1);
    sel6 = 3'd2;
    tick(1); @(negedge clk);
    check("n6_sel2_y", 32'(y6), 32'h A2);
    check("n6_sel2_ch", 32'(y_ch6), 2);
    check("n6_sel2_valid", 32'(y_valid6), 1);
    check("n6_err_sticky", 32'(sel_err6), 1);
    tick(1);
    reset_all();
    @(negedge clk);
    check("n6_rst_err", 32'(sel_err6), 0);
    check("n6_rst_valid", 32'(y_valid6), 0);
    tick(1);

    // ---- manual mode, table-driven, one select per cycle ----
    mon_on = 1'b1;
    mode = 1'b0; y_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = man_tbl[i].sel;
      en  = 1'b1;
      begin
        sb_item_t it;
        it.y  = man_tbl[i].exp_y;
        it.ch = man_tbl[i].exp_ch;
        sb_q.push_back(it);
      end
      tick(1);
    end
    en = 1'b0;
    wait_drain(20, "man_drain");
    @(negedge clk);
    check("man_idle_valid", 32'(y_valid), 0);

    // ---- scan, mask 1000_0101, pulses 4 cycles apart ----
    reset_all();
    mode = 1'b1; ch_mask = 8'b1000_0101; y_ready = 1'b1; en = 1'b1;
    gap_chk = 1'b1;
    push_exp(0); push_exp(2); push_exp(7); push_exp(0); push_exp(2);
    wait_drain(40, "scan_drain");
    en = 1'b0;
    gap_chk = 1'b0;

    // ---- backpressure in scan ----
    reset_all();
    y_ready = 1'b0; mode = 1'b1; ch_mask = 8'b1000_0101; en = 1'b1;
    push_exp(0); push_exp(2);
    tick(9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(y_valid), 1);
      check("bp_y", 32'(y), 32'h10);
      check("bp_y_ch", 32'(y_ch), 0);
      check("bp_dcnt", 32'(u_dut.dcnt_q), 3);
      check("bp_ptr", 32'(u_dut.ptr_q), 2);
      tick(1);
    end
    y_ready = 1'b1;
    tick(1);
    en = 1'b0;
    @(negedge clk);
    check("bp_refill_valid", 32'(y_valid), 1);
    check("bp_refill_ch", 32'(y_ch), 2);
    tick(1);
    wait_drain(5, "bp_drain");

    // ---- scan with empty mask, then a single channel ----
    reset_all();
    mode = 1'b1; ch_mask = 8'h00; y_ready = 1'b1; en = 1'b1;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (y_valid) n++;
    end
    check("mask0_no_valid", n, 0);
    check("mask0_ptr_hold", 32'(u_dut.ptr_q), 0);
    check("mask0_dcnt_hold", 32'(u_dut.dcnt_q), 0);
    tick(1);
    ch_mask = 8'h08;
    push_exp(3);
    wait_valid(10, n);
    check("mask8_first_edge", n, 5);
    check("mask8_ch", 32'(y_ch), 3);
    tick(1);
    en = 1'b0;
    wait_drain(5, "mask8_drain");

    // ---- reset while a sample is held under backpressure ----
    reset_all();
    y_ready = 1'b0; mode = 1'b1; ch_mask = 8'b1000_0101; en = 1'b1;
    tick(5);
    @(negedge clk);
    check("rmid_pre_valid", 32'(y_valid), 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("rmid_y", 32'(y), 0);
    check("rmid_y_ch", 32'(y_ch), 0);
    check("rmid_valid", 32'(y_valid), 0);
    check("rmid_ptr", 32'(u_dut.ptr_q), 0);
    check("rmid_dcnt", 32'(u_dut.dcnt_q), 0);
    sb_q.delete();
    tick(1);
    rst = 1'b0; y_ready = 1'b1;
    push_exp(0);
    wait_valid(10, n);
    check("rmid_restart_edge", n, 4);
    check("rmid_restart_ch", 32'(y_ch), 0);
    tick(1);
    en = 1'b0;
    wait_drain(5, "rmid_drain");

    mon_on = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_chan_scan_mux
